// File: rtl/dtn_arbiter_pkg.sv
// dtn_arbiter_pkg: shared constants and message type for the network injection arbiter
package dtn_arbiter_pkg;
    localparam int N_DEF  = 4;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 64;
    localparam int GAP_W  = 4;

    function automatic int ptr_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    localparam int PTR_W = ptr_w(N_DEF);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } msg_t;
endpackage

// File: rtl/dtn_round_robin_injector_rr_pick.sv
// rr_pick: combinational round-robin winner search starting at ptr, wrapping past N-1
module rr_pick #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic             found,
    output logic [PTR_W-1:0] idx
);
    logic [2*N-1:0] masked;
    logic [PTR_W:0] pos;

    // the upper copy of req is never masked, so it supplies the wrapped-around candidates
    assign masked = {req, req} & ~(((2*N)'(1) << ptr) - (2*N)'(1));

    always_comb begin
        pos = '0;
        for (int i = 2*N-1; i >= 0; i--)
            if (masked[i]) pos = (PTR_W+1)'(i);
        found = |req;
        idx = PTR_W'(pos >= (PTR_W+1)'(N) ? pos - (PTR_W+1)'(N) : pos);
    end
endmodule

// File: rtl/dtn_round_robin_injector.sv
// dtn_round_robin_injector: round-robin share of one nonblocking network port with a minimum injection gap
module dtn_round_robin_injector
    import dtn_arbiter_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DATA_WIDTH = DATA_W,
    parameter int INJECT_GAP = 1
) (
    input  logic                                clock,
    input  logic                                reset_n,
    input  logic                                enable,
    input  logic [N-1:0]                        in_valid,
    output logic [N-1:0]                        in_ready,
    input  logic [N-1:0][ADDR_WIDTH-1:0]        in_addr,
    input  logic [N-1:0][DATA_WIDTH-1:0]        in_data,
    output logic                                out_valid,
    output logic [ADDR_WIDTH-1:0]               out_addr,
    output logic [DATA_WIDTH-1:0]               out_data,
    output logic [$clog2(N)-1:0]                grant_idx,
    output logic                                busy
);
    localparam int PW = $clog2(N);

    logic [PW-1:0]    ptr, idx;
    logic [GAP_W-1:0] gap_cnt;
    logic             found, grant;

    rr_pick #(.N(N), .PTR_W(PW)) u_pick (
        .req  (in_valid),
        .ptr  (ptr),
        .found(found),
        .idx  (idx)
    );

    assign grant    = enable && reset_n && gap_cnt == '0 && found;
    assign in_ready = grant ? {{(N-1){1'b0}}, 1'b1} << idx : '0;
    assign busy     = gap_cnt != '0;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ptr       <= '0;
            gap_cnt   <= '0;
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_data  <= '0;
            grant_idx <= '0;
        end else begin
            out_valid <= grant;
            gap_cnt   <= grant ? GAP_W'(INJECT_GAP - 1) : busy ? gap_cnt - GAP_W'(1) : gap_cnt;
            if (grant) begin
                out_addr  <= in_addr[idx];
                out_data  <= in_data[idx];
                grant_idx <= idx;
                ptr       <= idx == PW'(N-1) ? '0 : idx + PW'(1);
            end
        end
    end
endmodule

// File: tb/tb_dtn_round_robin_injector.sv
// tb_dtn_round_robin_injector: directed and random stimulus on G=1 and G=3 instances against a timestamp-based model
module tb_dtn_round_robin_injector;
    localparam int N = 4;

    logic clock = 1'b0, reset_n = 1'b0, enable = 1'b0;
    logic [N-1:0] in_valid = '0;
    logic [N-1:0][3:0] in_addr;
    logic [N-1:0][63:0] in_data;
    logic [1:0][N-1:0] rdy;
    logic [1:0] ov, bz;
    logic [1:0][3:0] oa;
    logic [1:0][63:0] od;
    logic [1:0][1:0] gi;

    int checks = 0, errors = 0;
    int cyc = 0;
    int gap_of[2] = '{1, 3};
    int m_ptr[2], m_last[2], m_gi[2], win[2];
    logic m_ov[2];
    logic [3:0] m_oa[2];
    logic [63:0] m_od[2];

    always #5 clock = ~clock;

    dtn_round_robin_injector #(.N(N), .ADDR_WIDTH(4), .DATA_WIDTH(64), .INJECT_GAP(1)) dut_g1 (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .in_valid(in_valid), .in_ready(rdy[0]), .in_addr(in_addr), .in_data(in_data),
        .out_valid(ov[0]), .out_addr(oa[0]), .out_data(od[0]), .grant_idx(gi[0]), .busy(bz[0])
    );

    dtn_round_robin_injector #(.N(N), .ADDR_WIDTH(4), .DATA_WIDTH(64), .INJECT_GAP(3)) dut_g3 (
        .clock(clock), .reset_n(reset_n), .enable(enable),
        .in_valid(in_valid), .in_ready(rdy[1]), .in_addr(in_addr), .in_data(in_data),
        .out_valid(ov[1]), .out_addr(oa[1]), .out_data(od[1]), .grant_idx(gi[1]), .busy(bz[1])
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // one clock cycle: drive, check readies mid-cycle, then check registered outputs after the edge
    task automatic step(input logic [N-1:0] v, input logic en, input logic rn, input logic rnd);
        logic [N-1:0] exp_r;
        in_valid = v;
        enable   = en;
        reset_n  = rn;
        for (int k = 0; k < N; k++) begin
            in_addr[k] = rnd ? 4'($urandom) : 4'(k);
            in_data[k] = rnd ? {$urandom, $urandom} : 64'(k);
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            win[d] = -1;
            if (en && rn && cyc - m_last[d] >= gap_of[d] - 1)
                for (int j = 0; j < N; j++)
                    if (win[d] < 0 && v[(m_ptr[d] + j) % N]) win[d] = (m_ptr[d] + j) % N;
            exp_r = win[d] >= 0 ? N'(1) << win[d] : '0;
            chk($sformatf("ready_g%0d", gap_of[d]), 64'(rdy[d]), 64'(exp_r));
        end
        @(posedge clock);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (!rn) begin
                m_ptr[d] = 0; m_last[d] = -1000; m_ov[d] = 1'b0;
                m_oa[d] = '0; m_od[d] = '0; m_gi[d] = 0;
            end else if (win[d] >= 0) begin
                m_ov[d] = 1'b1;
                m_oa[d] = in_addr[win[d]];
                m_od[d] = in_data[win[d]];
                m_gi[d] = win[d];
                m_ptr[d] = (win[d] + 1) % N;
                m_last[d] = cyc;
            end else begin
                m_ov[d] = 1'b0;
            end
            chk($sformatf("out_valid_g%0d", gap_of[d]), 64'(ov[d]), 64'(m_ov[d]));
            chk($sformatf("out_addr_g%0d", gap_of[d]), 64'(oa[d]), 64'(m_oa[d]));
            chk($sformatf("out_data_g%0d", gap_of[d]), od[d], m_od[d]);
            chk($sformatf("grant_idx_g%0d", gap_of[d]), 64'(gi[d]), 64'(m_gi[d]));
            chk($sformatf("busy_g%0d", gap_of[d]), 64'(bz[d]), 64'(cyc - m_last[d] < gap_of[d] - 1));
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_last[d] = -1000; m_gi[d] = 0;
            m_ov[d] = 1'b0; m_oa[d] = '0; m_od[d] = '0;
        end
        // reset held with all requesters valid, then full-load round robin
        repeat (2) step(4'b1111, 1'b1, 1'b0, 1'b0);
        repeat (8) step(4'b1111, 1'b1, 1'b1, 1'b0);
        // single persistent requester
        step(4'b1111, 1'b1, 1'b0, 1'b0);
        repeat (9) step(4'b0100, 1'b1, 1'b1, 1'b0);
        // wrap and skip after in[2]
        repeat (7) step(4'b1010, 1'b1, 1'b1, 1'b0);
        repeat (4) step(4'b0001, 1'b1, 1'b1, 1'b0);
        // enable freeze after a grant to in[0]
        step(4'b0000, 1'b1, 1'b0, 1'b0);
        step(4'b0001, 1'b1, 1'b1, 1'b0);
        repeat (5) step(4'b0010, 1'b0, 1'b1, 1'b0);
        repeat (3) step(4'b0011, 1'b1, 1'b1, 1'b0);
        // reset the cycle after a grant
        step(4'b1111, 1'b1, 1'b1, 1'b0);
        step(4'b1111, 1'b1, 1'b0, 1'b0);
        repeat (3) step(4'b1111, 1'b1, 1'b1, 1'b0);
        // randomized traffic with occasional disable and reset
        repeat (400) step(4'($urandom), $urandom_range(0, 9) != 0, $urandom_range(0, 49) != 0, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
